// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg
// Shared definitions for the compare-unit arbiter:
//   - default operand / result / function-code widths and timeout length
//   - 2-bit FSM state encodings (IDLE, ISSUE, WAIT, RESP)
package cmp_arbiter_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_OUT_WIDTH      = 8;
  localparam int DEF_FUN_WIDTH      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   i_req   [1:0]  request vector, bit n = requester n pending
//   i_last         id of the requester served most recently
//   o_grant [1:0]  one-hot grant (all zero when nothing is requested)
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // Contention: the requester that was not served last wins.
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter
// Arbitrates two requesters onto one shared, registered compare unit.
// Each operation runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE: accept in IDLE,
// pulse CMP_EN in ISSUE, wait for CMP_VALID, then strobe the owner's RSPn_VALID.
// Optional feature: define CMP_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES
// cycles with RSP_ERR=1 and RSP_DATA=0; otherwise WAIT is unbounded and RSP_ERR=0.
// Ports:
//   CLK, RST (sync, active-low)
//   REQn_VALID/REQn_A/REQn_B/REQn_FUN in, REQn_READY out     (n = 0,1)
//   RSPn_VALID out, RSP_DATA/RSP_ERR out (shared, qualified by RSPn_VALID)
//   CMP_A/CMP_B/CMP_FUN/CMP_EN out, CMP_OUT/CMP_VALID in     (compare unit)
//   BUSY out, high whenever not IDLE
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int FUN_WIDTH      = DEF_FUN_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic [DATA_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ0_B,
  input  logic [FUN_WIDTH-1:0]  REQ0_FUN,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [DATA_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ1_B,
  input  logic [FUN_WIDTH-1:0]  REQ1_FUN,
  output logic                  REQ1_READY,
  output logic                  RSP0_VALID,
  output logic                  RSP1_VALID,
  output logic [OUT_WIDTH-1:0]  RSP_DATA,
  output logic                  RSP_ERR,
  output logic [DATA_WIDTH-1:0] CMP_A,
  output logic [DATA_WIDTH-1:0] CMP_B,
  output logic [FUN_WIDTH-1:0]  CMP_FUN,
  output logic                  CMP_EN,
  input  logic [OUT_WIDTH-1:0]  CMP_OUT,
  input  logic                  CMP_VALID,
  output logic                  BUSY
);

  logic [1:0]            r_state;
  logic                  r_owner;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic [OUT_WIDTH-1:0]  r_rsp_data;

  logic [1:0]            w_grant;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_timeout;

  rr_arb2 u_rr_arb2 (
    .i_req   ({REQ1_VALID, REQ0_VALID}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && (|w_grant);
  assign REQ0_READY = w_idle && w_grant[0];
  assign REQ1_READY = w_idle && w_grant[1];

  assign CMP_EN     = (r_state == ST_ISSUE);
  assign CMP_A      = r_a;
  assign CMP_B      = r_b;
  assign CMP_FUN    = r_fun;
  assign RSP_DATA   = r_rsp_data;
  assign RSP0_VALID = (r_state == ST_RESP) && !r_owner;
  assign RSP1_VALID = (r_state == ST_RESP) &&  r_owner;
  assign BUSY       = !w_idle;

`ifdef CMP_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_tcnt;
  logic          r_rsp_err;

  // r_tcnt holds the number of WAIT cycles already spent without CMP_VALID,
  // so the last permitted WAIT cycle is the one where it reaches TIMEOUT-1.
  assign w_timeout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign RSP_ERR   = r_rsp_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_tcnt    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT && !CMP_VALID) r_tcnt <= r_tcnt + TW'(1);
      else                                  r_tcnt <= '0;
      if (r_state == ST_WAIT) begin
        if (CMP_VALID)      r_rsp_err <= 1'b0;
        else if (w_timeout) r_rsp_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign RSP_ERR   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      // "Requester 1 served last" makes requester 0 the preferred winner.
      r_last     <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_fun      <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant[1] ? REQ1_A   : REQ0_A;
            r_b     <= w_grant[1] ? REQ1_B   : REQ0_B;
            r_fun   <= w_grant[1] ? REQ1_FUN : REQ0_FUN;
            r_owner <= w_grant[1];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          // CMP_VALID only matters here; stray strobes in other states fall through.
          if (CMP_VALID) begin
            r_rsp_data <= CMP_OUT;
            r_state    <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter
// Directed and randomized bench for cmp_arbiter, with a registered compare-unit
// model (CMP_VALID one cycle after CMP_EN) and an operation-level reference model.
module tb_cmp_arbiter;

  localparam int DW = 8;
  localparam int OW = 8;
  localparam int FW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ1_VALID;
  logic [DW-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [FW-1:0] REQ0_FUN, REQ1_FUN;
  logic          REQ0_READY, REQ1_READY;
  logic          RSP0_VALID, RSP1_VALID;
  logic [OW-1:0] RSP_DATA;
  logic          RSP_ERR;
  logic [DW-1:0] CMP_A, CMP_B;
  logic [FW-1:0] CMP_FUN;
  logic          CMP_EN;
  logic [OW-1:0] CMP_OUT;
  logic          CMP_VALID;
  logic          BUSY;

  int checks   = 0;
  int failures = 0;

  cmp_arbiter #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_FUN(CMP_FUN), .CMP_EN(CMP_EN),
    .CMP_OUT(CMP_OUT), .CMP_VALID(CMP_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Compare function: result is the function code when its relation holds, else 0.
  // 00: A<B, 01: A==B, 10: A>B, 11: A!=B
  function automatic logic [OW-1:0] cmp_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [FW-1:0] f);
    logic hit;
    case (f)
      2'd0:    hit = (a <  b);
      2'd1:    hit = (a == b);
      2'd2:    hit = (a >  b);
      default: hit = (a != b);
    endcase
    return hit ? OW'(f) : '0;
  endfunction

  // Registered compare unit; cu_auto=0 silences it, cu_force injects a strobe.
  logic          cu_auto  = 1'b1;
  logic          cu_force = 1'b0;
  logic          cu_vld   = 1'b0;
  logic [OW-1:0] cu_out   = '0;
  always @(posedge CLK) begin
    cu_vld <= cu_auto && CMP_EN;
    cu_out <= cmp_ref(CMP_A, CMP_B, CMP_FUN);
  end
  assign CMP_VALID = cu_vld | cu_force;
  assign CMP_OUT   = cu_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    REQ0_VALID = 1'b0; REQ0_A = '0; REQ0_B = '0; REQ0_FUN = '0;
    REQ1_VALID = 1'b0; REQ1_A = '0; REQ1_B = '0; REQ1_FUN = '0;
    cu_auto = 1'b1; cu_force = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  typedef struct { int cyc; int who; logic [OW-1:0] data; } rsp_t;
  rsp_t exp_q[$];

  int t0, t1, ng, busy_cnt, rsp_cnt, first_rsp;
  logic [OW-1:0] d0, d1, fr_data;
  logic fr_err, g0, g1;
  logic [1:0] pend, exp_r, acc;
  logic [DW-1:0] pa [2], pb [2];
  logic [FW-1:0] pf [2];
  int m_free, m_last, w;

  initial begin
    // ---------------- reset values
    do_reset();
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_cmp_en", CMP_EN, 0);
    check("rst_ready", {REQ1_READY, REQ0_READY}, 0);
    check("rst_rsp_valid", {RSP1_VALID, RSP0_VALID}, 0);
    check("rst_rsp_data", RSP_DATA, 0);
    check("rst_rsp_err", RSP_ERR, 0);
    check("rst_cmp_ops", {CMP_A, CMP_B, 6'(CMP_FUN)}, 0);

    // ---------------- single request, 5==5 with FUN=01
    REQ0_VALID = 1; REQ0_A = 5; REQ0_B = 5; REQ0_FUN = 2'b01;
    #1;
    check("single_ready", {REQ1_READY, REQ0_READY}, 2'b01);
    tick(); REQ0_VALID = 0; #1;
    check("single_cmp_en_c1", CMP_EN, 1);
    check("single_cmp_ops", {CMP_A, CMP_B, 6'(CMP_FUN)}, {8'd5, 8'd5, 6'd1});
    check("single_busy_c1", BUSY, 1);
    tick();
    check("single_cmp_en_c2", CMP_EN, 0);
    check("single_cmp_a_held", CMP_A, 5);
    check("single_rsp_c2", {RSP1_VALID, RSP0_VALID}, 0);
    tick();
    check("single_rsp_c3", {RSP1_VALID, RSP0_VALID}, 2'b01);
    check("single_data", RSP_DATA, 1);
    check("single_err", RSP_ERR, 0);
    tick();
    check("single_rsp_c4", {RSP1_VALID, RSP0_VALID}, 0);
    check("single_busy_c4", BUSY, 0);
    check("single_data_held", RSP_DATA, 1);

    // ---------------- simultaneous requests after reset
    do_reset();
    REQ0_VALID = 1; REQ0_A = 9; REQ0_B = 3; REQ0_FUN = 2'b10;
    REQ1_VALID = 1; REQ1_A = 2; REQ1_B = 7; REQ1_FUN = 2'b11;
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c == 0) check("simul_first_grant", {REQ1_READY, REQ0_READY}, 2'b01);
      g0 = REQ0_READY; g1 = REQ1_READY;
      if (RSP0_VALID && t0 < 0) begin t0 = c; d0 = RSP_DATA; end
      if (RSP1_VALID && t1 < 0) begin t1 = c; d1 = RSP_DATA; end
      tick();
      if (g0) REQ0_VALID = 0;
      if (g1) REQ1_VALID = 0;
    end
    check("simul_rsp0_cycle", t0, 3);
    check("simul_rsp0_data", d0, 2);
    check("simul_rsp1_cycle", t1, 7);
    check("simul_rsp1_data", d1, 3);
    check("simul_rsp_gap", t1 - t0, 4);

    // ---------------- fairness: both held valid, grants alternate 0,1,0,1...
    do_reset();
    REQ0_VALID = 1; REQ1_VALID = 1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      REQ0_A = DW'($urandom); REQ0_B = DW'($urandom); REQ0_FUN = FW'($urandom);
      REQ1_A = DW'($urandom); REQ1_B = DW'($urandom); REQ1_FUN = FW'($urandom);
      #1;
      if (REQ0_READY || REQ1_READY) begin
        check("fair_grant", {REQ1_READY, REQ0_READY}, (ng % 2 == 1) ? 2'b10 : 2'b01);
        ng++;
      end
      tick();
    end
    check("fair_count", ng, 8);
    REQ0_VALID = 0; REQ1_VALID = 0;

    // ---------------- reset while in WAIT, then a late CMP_VALID
    do_reset();
    cu_auto = 0;
    REQ1_VALID = 1; REQ1_A = 3; REQ1_B = 4; REQ1_FUN = 2'b00;
    tick(); REQ1_VALID = 0;   // ISSUE
    tick();                   // WAIT
    check("rstwait_busy_before", BUSY, 1);
    RST = 0;
    tick();
    RST = 1;
    check("rstwait_busy", BUSY, 0);
    check("rstwait_cmp_en", CMP_EN, 0);
    check("rstwait_rsp_valid", {RSP1_VALID, RSP0_VALID}, 0);
    check("rstwait_rsp_data", RSP_DATA, 0);
    check("rstwait_rsp_err", RSP_ERR, 0);
    check("rstwait_cmp_ops", {CMP_A, CMP_B, 6'(CMP_FUN)}, 0);
    cu_force = 1;
    rsp_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      cu_force = 0;
      if (RSP0_VALID || RSP1_VALID) rsp_cnt++;
      if (BUSY) busy_cnt++;
    end
    check("rstwait_late_rsp", rsp_cnt, 0);
    check("rstwait_late_busy", busy_cnt, 0);

    // ---------------- recovery op, leaves RSP_DATA nonzero
    cu_auto = 1;
    REQ0_VALID = 1; REQ0_A = 7; REQ0_B = 7; REQ0_FUN = 2'b01;
    tick(); REQ0_VALID = 0;
    tick(); tick();
    check("recover_rsp", {RSP1_VALID, RSP0_VALID}, 2'b01);
    check("recover_data", RSP_DATA, 1);
    tick();

    // ---------------- silent compare unit
    cu_auto = 0;
    REQ0_VALID = 1; REQ0_A = 1; REQ0_B = 2; REQ0_FUN = 2'b11;
    first_rsp = -1; fr_data = '1; fr_err = 1'b0;
`ifdef CMP_ARB_TIMEOUT_EN
    for (int c = 0; c < 12; c++) begin
      #1;
      if ((RSP0_VALID || RSP1_VALID) && first_rsp < 0) begin
        first_rsp = c; fr_data = RSP_DATA; fr_err = RSP_ERR;
        check("timeout_owner", {RSP1_VALID, RSP0_VALID}, 2'b01);
      end
      tick();
      REQ0_VALID = 0;
    end
    check("timeout_cycle", first_rsp, 6);
    check("timeout_err", fr_err, 1);
    check("timeout_data", fr_data, 0);
`else
    tick(); REQ0_VALID = 0;   // ISSUE
    rsp_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (BUSY) busy_cnt++;
      if (RSP0_VALID || RSP1_VALID) rsp_cnt++;
    end
    check("hang_busy_cycles", busy_cnt, 20);
    check("hang_no_rsp", rsp_cnt, 0);
    cu_force = 1;
    tick();
    cu_force = 0;
    check("hang_late_rsp", {RSP1_VALID, RSP0_VALID}, 2'b01);
    check("hang_late_data", RSP_DATA, 3);
    check("hang_late_err", RSP_ERR, 0);
    tick();
    check("hang_idle_after", BUSY, 0);
`endif
    cu_auto = 1;

    // ---------------- randomized traffic against the operation-level model
    do_reset();
    pend = 2'b00; m_free = 0; m_last = 1;
    exp_q.delete();
    for (int t = 0; t < 400; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          pa[n] = DW'($urandom_range(0, 7));
          pb[n] = DW'($urandom_range(0, 7));
          pf[n] = FW'($urandom);
        end
      end
      REQ0_VALID = pend[0]; REQ0_A = pa[0]; REQ0_B = pb[0]; REQ0_FUN = pf[0];
      REQ1_VALID = pend[1]; REQ1_A = pa[1]; REQ1_B = pb[1]; REQ1_FUN = pf[1];
      #1;
      exp_r = 2'b00; acc = 2'b00;
      if (t >= m_free && pend != 2'b00) begin
        if (pend == 2'b11) w = 1 - m_last;
        else               w = pend[1] ? 1 : 0;
        exp_r[w] = 1'b1;
        acc[w]   = 1'b1;
        exp_q.push_back('{cyc: t + 3, who: w, data: cmp_ref(pa[w], pb[w], pf[w])});
        m_free = t + 4;
        m_last = w;
      end
      check("rand_ready", {REQ1_READY, REQ0_READY}, exp_r);
      if (exp_q.size() > 0 && exp_q[0].cyc == t) begin
        check("rand_rsp_valid", {RSP1_VALID, RSP0_VALID}, (exp_q[0].who == 1) ? 2'b10 : 2'b01);
        check("rand_rsp_data", RSP_DATA, exp_q[0].data);
        check("rand_rsp_err", RSP_ERR, 0);
        void'(exp_q.pop_front());
      end else begin
        check("rand_rsp_idle", {RSP1_VALID, RSP0_VALID}, 2'b00);
      end
      tick();
      pend = pend & ~acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
